// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, ABI register indices and clog2 helper for the register file
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO = 0, RA = 1, SP = 2, GP = 3, TP = 4, T0 = 5, T1 = 6, T2 = 7;
  localparam int S0 = 8, S1 = 9, A0 = 10, A1 = 11, A2 = 12, A3 = 13, A4 = 14, A5 = 15;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve/clear priority and per-read-port busy lookup
// Ports: clk, rst (async active-low), we/wa write enables and addresses (clear),
//        rsv_en/rsv_addr reserve request (set), ra read addresses, rd_busy per-port flag, busy_vec scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NRD*AW-1:0] ra,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic [NREG-1:0]   busy_vec
);
  logic [NREG-1:0] busy_q, busy_d, clr;
  logic [AW-1:0] a;
  logic hit;
  // reserve is applied after clears so a newer producer wins over a same-cycle write
  always_comb begin
    clr = '0;
    for (int i = 0; i < NWR; i++) if (we[i]) clr[wa[i*AW +: AW]] = 1'b1;
    busy_d = busy_q & ~clr;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end
  always_comb begin
    rd_busy = '0;
    a = '0;
    hit = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      a = ra[j*AW +: AW];
      hit = 1'b0;
      for (int i = 0; i < NWR; i++) hit = hit | (we[i] && wa[i*AW +: AW] == a);
      rd_busy[j] = rst && busy_q[a] && !(BYPASS != 0 && hit && !(rsv_en && rsv_addr == a));
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with zero register, optional write-to-read bypass and busy scoreboard
// Ports: clk, rst (async active-low), we/wa/wd write ports, ra/rd read ports (combinational),
//        rsv_en/rsv_addr reserve, rd_busy per-read-port busy, busy_vec full scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NRD-1:0]      rd_busy,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [XLEN-1:0] v;
  logic [AW-1:0] a;
  // ascending port order makes the highest-index enabled port the winner
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NWR; i++) if (we[i]) mem_d[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
    if (ZERO_REG != 0) mem_d[0] = '0;
  end
  // bypass is gated by rst so nothing leaks to the read ports during reset
  always_comb begin
    rd = '0;
    v = '0;
    a = '0;
    for (int j = 0; j < NRD; j++) begin
      a = ra[j*AW +: AW];
      v = mem_q[a];
      if (BYPASS != 0)
        for (int i = 0; i < NWR; i++) if (we[i] && wa[i*AW +: AW] == a) v = wd[i*XLEN +: XLEN];
      if (ZERO_REG != 0 && a == '0) v = '0;
      rd[j*XLEN +: XLEN] = rst ? v : '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  regfile_scoreboard #(
    .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .ra(ra), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_busy(rd_busy), .busy_vec(busy_vec)
  );
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the single-cycle RISC-V core and its planned pipelined successor. It provides a configurable number of read and write ports, a hardwired zero register, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for producer tracking. It replaces the fixed 2-read/1-write register file in the datapath, with its read and write ports wired to the decoder and writeback.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of two, ≥ 2); AW = clog2(NREG)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads see pre-edge contents
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- we  in  NWR  per-port write enable
- wa  in  NWR*AW  write addresses, port i at bits [i*AW +: AW]
- wd  in  NWR*XLEN  write data, port i at bits [i*XLEN +: XLEN]
- ra  in  NRD*AW  read addresses
- rd  out  NRD*XLEN  read data (combinational)
- rsv_en  in  1  reserve request (mark destination busy)
- rsv_addr  in  AW  register to reserve
- rd_busy  out  NRD  busy flag of the register addressed by each read port
- busy_vec  out  NREG  full scoreboard

## Operation
- Storage: NREG × XLEN flops. Writes commit on the rising edge of clk when rst = 1.
- Write conflicts: if several enabled ports target the same address, the highest-index port wins. The other ports' data is discarded.
- Zero register (ZERO_REG = 1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - Reserves of address 0 are ignored; busy_vec[0] is always 0.
- Read path, for each read port j:
  - BYPASS = 1 and an enabled write port targets ra[j]: rd[j] = wd of the winning port.
  - Otherwise: rd[j] = stored value.
  - The zero rule overrides bypass.
- Scoreboard, updated at the clock edge:
  - rsv_en sets busy[rsv_addr].
  - Each enabled write clears busy[wa]; the clear applies even if the write data is dropped for address 0.
  - Reserve and write to the same address in one cycle: busy remains 1, because the reserve belongs to a newer producer.
  - rd_busy[j] = busy_vec[ra[j]]. When BYPASS = 1, a write to ra[j] in the current cycle with no same-cycle reserve of ra[j] forces rd_busy[j] = 0.
- Out-of-range addresses cannot occur, because NREG is a power of two.

## Timing
- Reset:
  - When rst = 0, all registers and all busy bits clear to 0 immediately (asynchronous).
  - While rst = 0: rd = 0, rd_busy = 0, busy_vec = 0.
  - Writes and reserves are ignored, and bypass is suppressed.
- Reset release: the first edge with rst = 1 accepts writes and reserves.
- Reset asserted mid-operation: any write or reserve pending at that edge is lost. The file returns to all zeros.
- Write latency:
  - 1 edge to storage.
  - BYPASS = 1: 0 cycles to the read ports.
  - BYPASS = 0: 1 cycle to the read ports.
- Reserve latency: busy_vec updates 1 edge after rsv_en.
- No handshake: every write and reserve is accepted unconditionally in one cycle.

## Structure
- Package regfile_pkg:
  - clog2 function
  - default XLEN/NREG constants
  - ABI register index constants (ZERO = 0, RA = 1, SP = 2, ...)
- Sub-module regfile_scoreboard: busy bits, reserve/clear priority logic, and rd_busy generation. It is parametrised by NREG, NRD and NWR, and takes the write-enable and address buses.
- Top level: storage array, write-priority resolution and the read/bypass mux.

## Test plan
- Reset: load registers 5 and 10, then pulse rst = 0 for 3 ns off-edge → rd = 0 and busy_vec = 0 immediately. After release, reading registers 5 and 10 returns 0.
- Write/read, BYPASS = 1: port0 writes 0xDEADBEEF to register 5 while ra[0] = 5 → rd[0] = 0xDEADBEEF in the same cycle, and it still reads 0xDEADBEEF after the edge.
  - Same stimulus with BYPASS = 0 → 0 before the edge, 0xDEADBEEF after.
- Conflict: port0 writes 0x11111111 and port1 writes 0x22222222, both to register 10 → register 10 = 0x22222222.
  - Ports writing different addresses in the same cycle (registers 3 and 4) → both stored.
- Zero register: write 0x12345678 to register 0 and reserve register 0 → rd = 0 and busy_vec[0] = 0.
- Scoreboard:
  - Reserve register 7 → busy_vec[7] = 1 after the edge.
  - Write register 7 with no reserve → busy_vec[7] = 0 after the edge.
  - Reserve and write register 7 in the same cycle → busy_vec[7] stays 1.
  - rd_busy[1] tracks ra[1] = 7 throughout.
- Two reads: store register 9 = 0xA5A5A5A5 and register 10 = 0x12345678, set ra = {10, 9} → rd[0] = 0xA5A5A5A5 and rd[1] = 0x12345678.
